bsg_mem_2rw_sync_mask_write_bit_fwd: RTL and testbench

Dual-port synchronous memory with per-bit write masks. Each port reads or writes one entry per cycle. It adds four behaviours to the plain 2rw masked memory:
- deterministic merging when both ports write the same address;
- read-during-write forwarding across ports;
- hold registers on both read outputs;
- an optional zero-initialisation sequence after reset, with a ready indication.

It sits beneath tag/state arrays and directory banks that need well-defined collision semantics instead of simulation-only assertions.

---
 rtl/bsg_mem_2rw_sync_mask_write_bit_fwd.sv | 123 ++++++++++++
 tb/tb_bsg_mem_2rw_sync_mask_write_bit_fwd.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_2rw_sync_mask_write_bit_fwd.sv
// Dual-port synchronous bit-masked memory with same-address write merging, cross-port
// read-during-write forwarding, held read outputs and optional zero-init after reset.
module bsg_mem_2rw_sync_mask_write_bit_fwd #(
    parameter int unsigned width_p         = 8,
    parameter int unsigned els_p           = 6,
    parameter int unsigned addr_width_lp   = (els_p == 1) ? 1 : $clog2(els_p),
    parameter bit          init_on_reset_p = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     a_v_i,
    input  logic                     a_w_i,
    input  logic [addr_width_lp-1:0] a_addr_i,
    input  logic [width_p-1:0]       a_data_i,
    input  logic [width_p-1:0]       a_w_mask_i,

    input  logic                     b_v_i,
    input  logic                     b_w_i,
    input  logic [addr_width_lp-1:0] b_addr_i,
    input  logic [width_p-1:0]       b_data_i,
    input  logic [width_p-1:0]       b_w_mask_i,

    output logic [width_p-1:0]       a_data_o,
    output logic [width_p-1:0]       b_data_o,
    output logic                     ready_o,
    output logic                     ww_collision_o
);

    typedef enum logic [1:0] {StReset, StInit, StReady} state_e;

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] cnt_q, cnt_d;
    logic [width_p-1:0]       mem [els_p];
    logic [width_p-1:0]       a_data_q, b_data_q;
    logic                     ww_q;

    logic               ready, init_we;
    logic               a_in_range, b_in_range, same_addr;
    logic               a_we, b_we, a_re, b_re;
    logic [width_p-1:0] a_old, b_old, a_wval, b_wval, a_merged, a_rval, b_rval;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StReset: state_d = init_on_reset_p ? StInit : StReady;
            StInit: begin
                if (cnt_q == addr_width_lp'(els_p - 1)) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StReset;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ready      = (state_q == StReady);
        init_we    = (state_q == StInit) && !reset_i;
        a_in_range = (32'(a_addr_i) < els_p);
        b_in_range = (32'(b_addr_i) < els_p);
        // Out-of-range addresses never alias each other for collision or forwarding.
        same_addr  = a_in_range && b_in_range && (a_addr_i == b_addr_i);

        a_we = ready && a_v_i && a_w_i && a_in_range;
        b_we = ready && b_v_i && b_w_i && b_in_range;
        a_re = ready && a_v_i && !a_w_i;
        b_re = ready && b_v_i && !b_w_i;

        a_old = a_in_range ? mem[a_addr_i] : '0;
        b_old = b_in_range ? mem[b_addr_i] : '0;

        b_wval   = (b_old & ~b_w_mask_i) | (b_data_i & b_w_mask_i);
        a_merged = (a_old & ~a_w_mask_i) | (a_data_i & a_w_mask_i);
        // A is layered over B's result on a shared address, so A wins overlapping bits.
        a_wval   = (((b_we && same_addr) ? b_wval : a_old) & ~a_w_mask_i)
                 | (a_data_i & a_w_mask_i);

        a_rval = (b_we && same_addr) ? b_wval : a_old;
        b_rval = (a_we && same_addr) ? a_merged : b_old;
    end

    always_ff @(posedge clk_i) begin
        if (init_we) begin
            mem[cnt_q] <= '0;
        end else begin
            if (b_we) mem[b_addr_i] <= b_wval;
            if (a_we) mem[a_addr_i] <= a_wval;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_data_q <= '0;
            b_data_q <= '0;
            ww_q     <= 1'b0;
        end else begin
            if (a_re) a_data_q <= a_rval;
            if (b_re) b_data_q <= b_rval;
            ww_q <= a_we && b_we && same_addr && (|(a_w_mask_i & b_w_mask_i));
        end
    end

    assign a_data_o       = a_data_q;
    assign b_data_o       = b_data_q;
    assign ready_o        = ready;
    assign ww_collision_o = ww_q;

endmodule

// File: tb/tb_bsg_mem_2rw_sync_mask_write_bit_fwd.sv
// Bench for bsg_mem_2rw_sync_mask_write_bit_fwd: directed vector table, init/reset sequences
// and randomized traffic against a bit-level reference model.
module tb_bsg_mem_2rw_sync_mask_write_bit_fwd;

    localparam int W  = 8;
    localparam int N  = 6;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          a_v, a_w, b_v, b_w;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_data, a_mask, b_data, b_mask;
    logic [W-1:0]  a_out, b_out;
    logic          ready, coll;

    bsg_mem_2rw_sync_mask_write_bit_fwd #(
        .width_p(W),
        .els_p(N),
        .init_on_reset_p(1'b1)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .a_v_i(a_v),
        .a_w_i(a_w),
        .a_addr_i(a_addr),
        .a_data_i(a_data),
        .a_w_mask_i(a_mask),
        .b_v_i(b_v),
        .b_w_i(b_w),
        .b_addr_i(b_addr),
        .b_data_i(b_data),
        .b_w_mask_i(b_mask),
        .a_data_o(a_out),
        .b_data_o(b_out),
        .ready_o(ready),
        .ww_collision_o(coll)
    );

    typedef struct {
        logic          av, aw;
        logic [AW-1:0] aa;
        logic [W-1:0]  ad, am;
        logic          bv, bw;
        logic [AW-1:0] ba;
        logic [W-1:0]  bd, bm;
        logic [W-1:0]  ea, eb;
        logic          ec;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mdl_mem [N];
    logic [W-1:0] mdl_a, mdl_b;
    logic         mdl_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int av, input int aw, input int aa, input int ad, input int am,
                         input int bv, input int bw, input int ba, input int bd, input int bm);
        a_v = 1'(av);  a_w = 1'(aw);  a_addr = AW'(aa);  a_data = W'(ad);  a_mask = W'(am);
        b_v = 1'(bv);  b_w = 1'(bw);  b_addr = AW'(ba);  b_data = W'(bd);  b_mask = W'(bm);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic vec_t mk(input int av, input int aw, input int aa, input int ad,
                                input int am, input int bv, input int bw, input int ba,
                                input int bd, input int bm, input int ea, input int eb,
                                input int ec);
        vec_t v;
        v.av = 1'(av); v.aw = 1'(aw); v.aa = AW'(aa); v.ad = W'(ad); v.am = W'(am);
        v.bv = 1'(bv); v.bw = 1'(bw); v.ba = AW'(ba); v.bd = W'(bd); v.bm = W'(bm);
        v.ea = W'(ea); v.eb = W'(eb); v.ec = 1'(ec);
        return v;
    endfunction

    task automatic model_clear();
        for (int e = 0; e < N; e++) mdl_mem[e] = '0;
        mdl_a = '0;
        mdl_b = '0;
        mdl_c = 1'b0;
    endtask

    // Bitwise: each bit goes to A's data if A writes it, else B's if B writes it.
    // Reads see the resulting memory, which is the post-write value of the other port.
    task automatic model_step();
        logic [W-1:0] nm [N];
        logic awe, bwe;
        awe = a_v && a_w && (int'(a_addr) < N);
        bwe = b_v && b_w && (int'(b_addr) < N);
        for (int e = 0; e < N; e++) begin
            nm[e] = mdl_mem[e];
            for (int i = 0; i < W; i++) begin
                if (awe && int'(a_addr) == e && a_mask[i]) nm[e][i] = a_data[i];
                else if (bwe && int'(b_addr) == e && b_mask[i]) nm[e][i] = b_data[i];
            end
        end
        if (a_v && !a_w) mdl_a = (int'(a_addr) < N) ? nm[int'(a_addr)] : '0;
        if (b_v && !b_w) mdl_b = (int'(b_addr) < N) ? nm[int'(b_addr)] : '0;
        mdl_c = awe && bwe && (a_addr == b_addr) && ((a_mask & b_mask) != '0);
        for (int e = 0; e < N; e++) mdl_mem[e] = nm[e];
    endtask

    vec_t vecs[$];

    initial begin
        // Directed vectors, applied from an all-zero memory with zeroed outputs.
        vecs.push_back(mk(1,1,2,'hAB,'hFF, 0,0,0,0,0,       'h00,'h00,0));
        vecs.push_back(mk(1,0,2,0,0,       0,0,0,0,0,       'hAB,'h00,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       'hAB,'h00,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       'hAB,'h00,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       'hAB,'h00,0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       'hAB,'h00,0));
        vecs.push_back(mk(0,0,0,0,0,       1,1,2,'h05,'h0F, 'hAB,'h00,0));
        vecs.push_back(mk(1,1,3,'hF0,'hFC, 1,1,3,'h0F,'h3F, 'hAB,'h00,1));
        vecs.push_back(mk(1,0,3,0,0,       0,0,0,0,0,       'hF3,'h00,0));
        vecs.push_back(mk(1,1,3,'hF0,'hF0, 1,1,3,'h0F,'h0F, 'hF3,'h00,0));
        vecs.push_back(mk(1,0,3,0,0,       0,0,0,0,0,       'hFF,'h00,0));
        vecs.push_back(mk(1,1,1,'h11,'hFF, 0,0,0,0,0,       'hFF,'h00,0));
        vecs.push_back(mk(1,1,1,'hEE,'hF0, 1,0,1,0,0,       'hFF,'hE1,0));
        vecs.push_back(mk(0,0,0,0,0,       1,0,1,0,0,       'hFF,'hE1,0));
        vecs.push_back(mk(1,1,7,'h77,'hFF, 1,1,7,'h55,'hFF, 'hFF,'hE1,0));
        vecs.push_back(mk(1,0,6,0,0,       1,0,2,0,0,       'h00,'hA5,0));
        vecs.push_back(mk(1,1,0,'h3C,'h00, 1,0,0,0,0,       'h00,'h00,0));
        vecs.push_back(mk(1,1,4,'hFF,'h01, 1,1,4,'h00,'h01, 'h00,'h00,1));
        vecs.push_back(mk(1,1,4,'hFF,'h01, 1,1,4,'h00,'h01, 'h00,'h00,1));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       'h00,'h00,0));
        vecs.push_back(mk(1,0,4,0,0,       1,0,4,0,0,       'h01,'h01,0));
        vecs.push_back(mk(1,0,0,0,0,       1,0,5,0,0,       'h00,'h00,0));

        // Reset, then exactly N cycles of init before ready.
        reset = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_ready", 32'(ready), 0);
            check("reset_a_data", 32'(a_out), 0);
            check("reset_b_data", 32'(b_out), 0);
            check("reset_coll", 32'(coll), 0);
        end
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            tick();
            check("init_ready_low", 32'(ready), 0);
        end
        tick();
        check("init_ready_high", 32'(ready), 1);
        model_clear();

        for (int e = 0; e < N; e++) begin
            drive(1, 0, e, 0, 0, 1, 0, N - 1 - e, 0, 0);
            tick();
            check("init_zero_a", 32'(a_out), 0);
            check("init_zero_b", 32'(b_out), 0);
        end
        idle();

        for (int k = 0; k < vecs.size(); k++) begin
            drive(int'(vecs[k].av), int'(vecs[k].aw), int'(vecs[k].aa), int'(vecs[k].ad),
                  int'(vecs[k].am), int'(vecs[k].bv), int'(vecs[k].bw), int'(vecs[k].ba),
                  int'(vecs[k].bd), int'(vecs[k].bm));
            model_step();
            tick();
            check($sformatf("vec%0d_a_data", k), 32'(a_out), 32'(vecs[k].ea));
            check($sformatf("vec%0d_b_data", k), 32'(b_out), 32'(vecs[k].eb));
            check($sformatf("vec%0d_coll", k), 32'(coll), 32'(vecs[k].ec));
        end
        idle();

        // Randomized traffic; addresses include out-of-range 6 and 7.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) < 8) ? 1 : 0, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 8) ? 1 : 0, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
            model_step();
            tick();
            check("rand_a_data", 32'(a_out), 32'(mdl_a));
            check("rand_b_data", 32'(b_out), 32'(mdl_b));
            check("rand_coll", 32'(coll), 32'(mdl_c));
            check("rand_ready", 32'(ready), 1);
        end
        idle();

        // Reset aborted at init cycle 3; requests during the restarted init are ignored.
        reset = 1'b1;
        tick();
        tick();
        check("reset2_a_data", 32'(a_out), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_ready_low", 32'(ready), 0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i % 2 == 0) drive(1, 1, 0, 'h77, 'hFF, 1, 1, 5, 'h99, 'hFF);
            else            drive(1, 0, 2, 0, 0, 1, 0, 3, 0, 0);
            tick();
            check("reinit_ready_low", 32'(ready), 0);
            check("reinit_a_data", 32'(a_out), 0);
            check("reinit_b_data", 32'(b_out), 0);
        end
        idle();
        tick();
        check("reinit_ready_high", 32'(ready), 1);
        model_clear();
        for (int e = 0; e < N; e++) begin
            drive(1, 0, e, 0, 0, 1, 0, e, 0, 0);
            tick();
            check("reinit_zero_a", 32'(a_out), 0);
            check("reinit_zero_b", 32'(b_out), 0);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
